// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Instruction fetch stage sitting behind the BIOS ROM and the main
// instruction memory. Owns the program counter, fetches from the BIOS ROM
// while booting, switches to instruction memory when the Start System
// opcode is fetched, and presents one registered instruction per cycle to
// decode. Handles redirects from execute, stalls from decode and halt.
//
// Ports:
//   clock              rising-edge clock
//   reset              asynchronous, active-low reset
//   stall              decode back-pressure; hold PC and instruction outputs
//   jump_valid         redirect request from execute
//   jump_target        redirect address in the current memory space
//   resume             leave HALT and continue at the held PC
//   bios_address       BIOS ROM address (combinational from PC)
//   bios_data          BIOS ROM word
//   imem_address       instruction memory address (combinational from PC)
//   imem_data          instruction memory word
//   instruction        registered instruction to decode
//   instruction_pc     address of instruction
//   instruction_valid  instruction is live
//   boot_mode          1 while the BIOS is the active memory space
//   halted             1 in HALT
//   bios_error         sticky; BIOS PC went out of range
//
// Configuration macro: BOOT_BYPASS_EN
//   When defined the sequencer comes out of reset in RUN, never addresses
//   the BIOS and bios_error is tied low.

module fetch_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int BIOS_DEPTH = 37
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              resume,
  output logic [ADDR_W-1:0] bios_address,
  input  logic [DATA_W-1:0] bios_data,
  output logic [ADDR_W-1:0] imem_address,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] instruction_pc,
  output logic              instruction_valid,
  output logic              boot_mode,
  output logic              halted,
  output logic              bios_error
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [5:0] OP_START_SYSTEM = 6'b100111;
  localparam logic [5:0] OP_HLT          = 6'b011100;
  localparam logic [ADDR_W-1:0] BIOS_LIMIT = ADDR_W'(BIOS_DEPTH);

`ifdef BOOT_BYPASS_EN
  localparam state_t RESET_STATE = RUN;
  localparam logic   RESET_SPACE = 1'b0;
`else
  localparam state_t RESET_STATE = BOOT;
  localparam logic   RESET_SPACE = 1'b1;
`endif

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [DATA_W-1:0] instr_q, instr_n;
  logic [ADDR_W-1:0] ipc_q, ipc_n;
  logic              valid_q, valid_n;
  // bios_space remembers which memory is active, so a HALT knows where
  // to return to on resume.
  logic              bios_space, bios_space_n;
  logic              err_q, err_n;

  logic [DATA_W-1:0] fetched;
  logic [5:0]        opcode;
  logic              out_of_range;

  assign fetched = bios_space ? bios_data : imem_data;
  assign opcode  = fetched[31:26];

`ifdef BOOT_BYPASS_EN
  assign out_of_range = 1'b0;
  assign bios_address = '0;
  assign bios_error   = 1'b0;
`else
  assign out_of_range = bios_space && (pc >= BIOS_LIMIT);
  assign bios_address = bios_space ? pc : '0;
  assign bios_error   = err_q;
`endif

  assign imem_address      = bios_space ? '0 : pc;
  assign instruction       = instr_q;
  assign instruction_pc    = ipc_q;
  assign instruction_valid = valid_q;
  assign boot_mode         = bios_space;
  assign halted            = (state == HALT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= RESET_STATE;
      pc         <= '0;
      instr_q    <= '0;
      ipc_q      <= '0;
      valid_q    <= 1'b0;
      bios_space <= RESET_SPACE;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      instr_q    <= instr_n;
      ipc_q      <= ipc_n;
      valid_q    <= valid_n;
      bios_space <= bios_space_n;
      err_q      <= err_n;
    end
  end

  // Priority in BOOT/RUN: redirect, then stall, then BIOS range error,
  // then the Start System handoff, then a normal issue (which may be Hlt).
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    instr_n      = instr_q;
    ipc_n        = ipc_q;
    valid_n      = valid_q;
    bios_space_n = bios_space;
    err_n        = err_q;

    case (state)
      HALT: begin
        valid_n = 1'b0;
        // A HALT caused by a BIOS range error is only left through reset.
        if (resume && !err_q) begin
          state_n = bios_space ? BOOT : RUN;
        end
      end
      default: begin
        if (jump_valid) begin
          pc_n    = jump_target;
          valid_n = 1'b0;
        end else if (stall) begin
          valid_n = valid_q;
        end else if (state == BOOT && out_of_range) begin
          valid_n = 1'b0;
          err_n   = 1'b1;
          state_n = HALT;
        end else if (state == BOOT && opcode == OP_START_SYSTEM) begin
          valid_n      = 1'b0;
          state_n      = RUN;
          bios_space_n = 1'b0;
          pc_n         = '0;
        end else begin
          instr_n = fetched;
          ipc_n   = pc;
          valid_n = 1'b1;
          pc_n    = pc + 1'b1;
          if (opcode == OP_HLT) begin
            state_n = HALT;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//
// Table-driven bench for fetch_sequencer with behavioural BIOS ROM and
// instruction memory models. Each vector holds the inputs for one cycle
// and the outputs expected after that cycle's rising edge.

module tb_fetch_sequencer;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              stall = 1'b0;
  logic              jump_valid = 1'b0;
  logic [ADDR_W-1:0] jump_target = '0;
  logic              resume = 1'b0;
  logic [ADDR_W-1:0] bios_address;
  logic [DATA_W-1:0] bios_data;
  logic [ADDR_W-1:0] imem_address;
  logic [DATA_W-1:0] imem_data;
  logic [DATA_W-1:0] instruction;
  logic [ADDR_W-1:0] instruction_pc;
  logic              instruction_valid;
  logic              boot_mode;
  logic              halted;
  logic              bios_error;

  logic [DATA_W-1:0] bios_mem [0:1023];
  logic [DATA_W-1:0] imem_mem [0:1023];

  assign bios_data = bios_mem[bios_address];
  assign imem_data = imem_mem[imem_address];

  fetch_sequencer dut (
    .clock             (clock),
    .reset             (reset),
    .stall             (stall),
    .jump_valid        (jump_valid),
    .jump_target       (jump_target),
    .resume            (resume),
    .bios_address      (bios_address),
    .bios_data         (bios_data),
    .imem_address      (imem_address),
    .imem_data         (imem_data),
    .instruction       (instruction),
    .instruction_pc    (instruction_pc),
    .instruction_valid (instruction_valid),
    .boot_mode         (boot_mode),
    .halted            (halted),
    .bios_error        (bios_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic              st;
    logic              jv;
    logic [ADDR_W-1:0] jt;
    logic              rs;
    logic              e_valid;
    logic [DATA_W-1:0] e_instr;
    logic [ADDR_W-1:0] e_pc;
    logic              e_boot;
    logic              e_halt;
    logic              e_err;
  } vec_t;

  vec_t tbl_main[$];
  vec_t tbl_err[$];
  vec_t scoreboard[$];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic st, logic jv, logic [ADDR_W-1:0] jt,
                              logic rs, logic ev, logic [DATA_W-1:0] ei,
                              logic [ADDR_W-1:0] ep, logic eb, logic eh,
                              logic ee);
    vec_t v;
    v.st = st; v.jv = jv; v.jt = jt; v.rs = rs;
    v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
    v.e_boot = eb; v.e_halt = eh; v.e_err = ee;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle: queue the expectation, clock, then retire it.
  task automatic apply_stimulus(input vec_t v, input string tag);
    vec_t e;
    stall       = v.st;
    jump_valid  = v.jv;
    jump_target = v.jt;
    resume      = v.rs;
    scoreboard.push_back(v);
    @(posedge clock);
    #1;
    e = scoreboard.pop_front();
    check_output({tag, " valid"}, 32'(instruction_valid), 32'(e.e_valid));
    if (e.e_valid) begin
      check_output({tag, " instr"}, instruction, e.e_instr);
      check_output({tag, " ipc"}, 32'(instruction_pc), 32'(e.e_pc));
    end
    check_output({tag, " boot"}, 32'(boot_mode), 32'(e.e_boot));
    check_output({tag, " halted"}, 32'(halted), 32'(e.e_halt));
    check_output({tag, " err"}, 32'(bios_error), 32'(e.e_err));
    if (e.e_boot) check_output({tag, " imem_addr"}, 32'(imem_address), 32'd0);
    else          check_output({tag, " bios_addr"}, 32'(bios_address), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " instr"}, instruction, 32'd0);
    check_output({tag, " ipc"}, 32'(instruction_pc), 32'd0);
    check_output({tag, " valid"}, 32'(instruction_valid), 32'd0);
    check_output({tag, " boot"}, 32'(boot_mode), 32'd1);
    check_output({tag, " halted"}, 32'(halted), 32'd0);
    check_output({tag, " err"}, 32'(bios_error), 32'd0);
    check_output({tag, " bios_addr"}, 32'(bios_address), 32'd0);
  endtask

  function automatic logic [DATA_W-1:0] bw(int i);
    return bios_mem[i];
  endfunction

  function automatic logic [DATA_W-1:0] iw(int i);
    return imem_mem[i];
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      bios_mem[i] = 32'h0400_0000 + 32'(i);
      imem_mem[i] = 32'h0800_0000 + 32'(i);
    end
    bios_mem[0]  = 32'h6C00_0000;
    bios_mem[34] = 32'h9C00_0000;
    imem_mem[5]  = 32'h7000_0000;
    imem_mem[8]  = 32'h9C00_0008;

    // Boot stream, stall, redirects, Start System handoff, Hlt and resume.
    tbl_main.push_back(mk(0,0, 0,0, 1, bw(0),  0, 1,0,0));
    tbl_main.push_back(mk(0,0, 0,0, 1, bw(1),  1, 1,0,0));
    tbl_main.push_back(mk(0,0, 0,0, 1, bw(2),  2, 1,0,0));
    tbl_main.push_back(mk(1,0, 0,0, 1, bw(2),  2, 1,0,0));
    tbl_main.push_back(mk(1,0, 0,0, 1, bw(2),  2, 1,0,0));
    tbl_main.push_back(mk(1,0, 0,0, 1, bw(2),  2, 1,0,0));
    tbl_main.push_back(mk(0,0, 0,0, 1, bw(3),  3, 1,0,0));
    tbl_main.push_back(mk(0,0, 0,0, 1, bw(4),  4, 1,0,0));
    tbl_main.push_back(mk(0,1,20,0, 0, 0,      0, 1,0,0));
    tbl_main.push_back(mk(0,1,13,0, 0, 0,      0, 1,0,0));
    tbl_main.push_back(mk(0,0, 0,0, 1, bw(13),13, 1,0,0));
    tbl_main.push_back(mk(0,0, 0,0, 1, bw(14),14, 1,0,0));
    tbl_main.push_back(mk(0,1,34,0, 0, 0,      0, 1,0,0));
    tbl_main.push_back(mk(0,1,30,0, 0, 0,      0, 1,0,0));
    for (int i = 30; i < 34; i++)
      tbl_main.push_back(mk(0,0,0,0, 1, bw(i), ADDR_W'(i), 1,0,0));
    tbl_main.push_back(mk(0,0, 0,0, 0, 0,      0, 0,0,0));
    for (int i = 0; i < 5; i++)
      tbl_main.push_back(mk(0,0,0,0, 1, iw(i), ADDR_W'(i), 0,0,0));
    tbl_main.push_back(mk(0,0, 0,0, 1, 32'h7000_0000, 5, 0,1,0));
    tbl_main.push_back(mk(0,1, 2,0, 0, 0,      0, 0,1,0));
    tbl_main.push_back(mk(1,0, 0,0, 0, 0,      0, 0,1,0));
    tbl_main.push_back(mk(0,0, 0,0, 0, 0,      0, 0,1,0));
    tbl_main.push_back(mk(0,0, 0,1, 0, 0,      0, 0,0,0));
    tbl_main.push_back(mk(0,0, 0,0, 1, iw(6),  6, 0,0,0));
    tbl_main.push_back(mk(0,0, 0,0, 1, iw(7),  7, 0,0,0));
    tbl_main.push_back(mk(0,0, 0,0, 1, 32'h9C00_0008, 8, 0,0,0));

    // Out-of-range BIOS run after a jump to the last valid word.
    tbl_err.push_back(mk(0,0, 0,0, 1, bw(0),  0, 1,0,0));
    tbl_err.push_back(mk(0,1,36,0, 0, 0,      0, 1,0,0));
    tbl_err.push_back(mk(0,0, 0,0, 1, bw(36),36, 1,0,0));
    tbl_err.push_back(mk(0,0, 0,0, 0, 0,      0, 1,1,1));
    tbl_err.push_back(mk(0,0, 0,1, 0, 0,      0, 1,1,1));
    tbl_err.push_back(mk(0,0, 0,0, 0, 0,      0, 1,1,1));

    // Reset held across a couple of edges, released away from an edge.
    repeat (2) @(posedge clock);
    #1;
    check_reset_values("reset");
    reset = 1'b1;

    foreach (tbl_main[i])
      apply_stimulus(tbl_main[i], $sformatf("main[%0d]", i));

    // Asynchronous reset in mid-cycle must take effect without a clock edge.
    #3;
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    bios_mem[34] = 32'h0400_0022;
    @(posedge clock);
    #1;
    reset = 1'b1;

    foreach (tbl_err[i])
      apply_stimulus(tbl_err[i], $sformatf("err[%0d]", i));

    #3;
    reset = 1'b0;
    #1;
    check_reset_values("errreset");

    if (scoreboard.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: got %0d left expected 0", scoreboard.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch stage directly downstream of the BIOS ROM and the main instruction memory. Holds the program counter, drives the ROM address while booting, and hands off to instruction memory when the Start System opcode is fetched. Presents one registered 32-bit instruction per cycle to decode. Also handles redirects from execute, stalls from decode, and halt.

## Interface
- ADDR_W, 10, program counter and memory address width
- DATA_W, 32, instruction width
- BIOS_DEPTH, 37, number of valid BIOS words; addresses at or above this are out of range
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  decode back-pressure; hold PC and instruction outputs
- jump_valid  in  1  redirect request from execute
- jump_target  in  ADDR_W  redirect address; space is the current mode's memory
- resume  in  1  leave HALT and continue at the held PC
- bios_address  out  ADDR_W  BIOS ROM address (combinational from PC)
- bios_data  in  DATA_W  BIOS ROM word, combinational from bios_address
- imem_address  out  ADDR_W  instruction memory address (combinational from PC)
- imem_data  in  DATA_W  instruction memory word, combinational
- instruction  out  DATA_W  registered instruction to decode
- instruction_pc  out  ADDR_W  address of instruction
- instruction_valid  out  1  instruction is live
- boot_mode  out  1  1 while fetching from BIOS
- halted  out  1  1 in HALT
- bios_error  out  1  sticky; BIOS PC went out of range

## Operation
- States: BOOT, RUN, HALT. Opcode is bits [31:26]: Start System 6'b100111, Hlt 6'b011100, Nop 6'b011011.
- The fetched word is bios_data in BOOT and imem_data in RUN. The inactive address output holds 0.
- Normal cycle (no stall, no jump, not HALT):
  - instruction <= fetched word, instruction_pc <= PC, instruction_valid <= 1, PC <= PC+1.
  - PC arithmetic is modulo 2^ADDR_W (1023+1 = 0).
- Start System fetched in BOOT:
  - Word is consumed: instruction_valid <= 0.
  - State -> RUN, PC <= 0, boot_mode falls on the same edge.
  - Start System fetched in RUN is passed through as an ordinary word.
- Hlt fetched in BOOT or RUN:
  - Word is issued valid; state -> HALT; PC <= PC+1.
  - HALT is entered from whichever mode was active. The mode is remembered for resume.
- HALT:
  - instruction_valid <= 0; PC frozen; stall and jump_valid ignored.
  - resume -> previous mode, fetching at the held PC on the next cycle.
- Redirect (jump_valid, not HALT):
  - PC <= jump_target; instruction_valid <= 0, squashing the word fetched this cycle.
  - Jump has priority over stall and over a Start System or Hlt fetched the same cycle. That word is squashed and its effect is not taken.
- stall without jump: all registers hold.
- BOOT with PC >= BIOS_DEPTH:
  - Fetched word is not issued; bios_error <= 1; state -> HALT.
  - resume from this HALT is ignored; only reset clears it.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state BOOT, PC 0, instruction 0, instruction_pc 0.
  - instruction_valid 0, boot_mode 1, halted 0, bios_error 0.
- Address to instruction latency: 1 cycle. The word at PC appears on instruction after the next rising edge.
- First valid instruction (BIOS word 0): the first edge after reset release.
- Redirect penalty: 1 bubble. Target word is valid 2 edges after jump_valid is sampled.
- Start System handoff: 1 bubble. imem word 0 is valid on the second edge after Start System is fetched.
- halted rises on the same edge that issues the Hlt word.
- Reset mid-operation immediately forces all reset values regardless of state.

## Configuration
- BOOT_BYPASS_EN:
  - When defined, reset state is RUN with boot_mode 0; BIOS is never addressed (bios_address fixed at 0); bios_error is tied 0. Used for simulation with preloaded instruction memory.
  - When undefined, behaviour is as above.

## Test plan
- Reset release, BIOS holds Nop, Loadi, Output:
  - Words 0, 1, 2 issue on edges 1, 2, 3 with instruction_pc 0, 1, 2.
  - boot_mode stays 1.
- BIOS word 34 = 32'h9C000000 (Start System):
  - One bubble, boot_mode drops, then imem word 0 issues with instruction_pc 0.
- jump_valid with target 13 while fetching BIOS word 20:
  - Word 20 squashed; BIOS word 13 issues next with instruction_pc 13.
  - Same cycle as Start System fetch: mode stays BOOT.
- stall held 3 cycles mid-stream:
  - instruction, instruction_pc and PC unchanged.
  - The following word issues exactly once after release.
- imem word 5 = 32'h70000000 (Hlt):
  - Hlt issued valid, halted 1, valid 0 thereafter, jump ignored.
  - resume: imem word 6 issues.
- BIOS without Start System, jump to 36 then run on:
  - Word 36 issues; at PC 37, bios_error 1, halted 1, resume ignored.
  - Reset clears both.
